qq_seq_ctrl: RTL and testbench

Sequencer that drives the echo-window coder of the 2D NMR FPGA. On a start pulse it latches a sequence length, step period and repetition count. It then steps the 5-bit `count` bus from 0 to the programmed length, holding each value for a programmable number of `clk_sys` cycles, and raises `state_start` while a sequence is active. It repeats this for N repetitions, then pulses `done`. It sits between the acquisition control registers and the coder that compares `count` against its three window parameters.

---
 rtl/qq_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_qq_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qq_seq_ctrl.sv
// rtl/qq_seq_ctrl.sv - echo-window step sequencer driving the coder's count bus.
// Optional inter-repetition gap state and gap_len port enabled by QQ_SEQ_GAP_EN.
module qq_seq_ctrl (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic [4:0]  seq_len,
   input  logic [15:0] step_period,
   input  logic [7:0]  repeat_num,
`ifdef QQ_SEQ_GAP_EN
   input  logic [15:0] gap_len,
`endif
   output logic [4:0]  count,
   output logic        state_start,
   output logic [7:0]  rep_cnt,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
`ifdef QQ_SEQ_GAP_EN
      , S_GAP = 2'd3
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [7:0]  rep_q, rep_d;
   logic [15:0] tick_q, tick_d;
   logic [4:0]  len_q, len_d;
   logic [15:0] per_q, per_d;
   logic [7:0]  num_q, num_d;
   logic        ss_q, ss_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
`ifdef QQ_SEQ_GAP_EN
   logic [15:0] gap_q, gap_d;
   logic [15:0] gcnt_q, gcnt_d;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rep_d   = rep_q;
      tick_d  = tick_q;
      len_d   = len_q;
      per_d   = per_q;
      num_d   = num_q;
`ifdef QQ_SEQ_GAP_EN
      gap_d   = gap_q;
      gcnt_d  = gcnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            count_d = 5'd0;
            rep_d   = 8'd0;
            if (start && !stop) begin
               len_d  = seq_len;
               per_d  = (step_period == 16'd0) ? 16'd1 : step_period;
               num_d  = repeat_num;
`ifdef QQ_SEQ_GAP_EN
               gap_d  = gap_len;
`endif
               tick_d = 16'd0;
               state_d = (repeat_num == 8'd0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
               count_d = 5'd0;
               rep_d   = 8'd0;
            end else if (tick_q == per_q - 16'd1) begin
               tick_d = 16'd0;
               if (count_q < len_q) begin
                  count_d = count_q + 5'd1;
               end else if (rep_q == num_q - 8'd1) begin
                  state_d = S_DONE;
                  count_d = 5'd0;
               end else begin
                  rep_d   = rep_q + 8'd1;
                  count_d = 5'd0;
`ifdef QQ_SEQ_GAP_EN
                  if (gap_q != 16'd0) begin
                     state_d = S_GAP;
                     gcnt_d  = 16'd0;
                  end
`endif
               end
            end else begin
               tick_d = tick_q + 16'd1;
            end
         end
`ifdef QQ_SEQ_GAP_EN
         S_GAP: begin
            count_d = 5'd0;
            if (stop) begin
               state_d = S_IDLE;
               rep_d   = 8'd0;
            end else if (gcnt_q == gap_q - 16'd1) begin
               state_d = S_RUN;
               tick_d  = 16'd0;
            end else begin
               gcnt_d = gcnt_q + 16'd1;
            end
         end
`endif
         S_DONE: begin
            // rep_cnt holds its final value only for the DONE cycle itself
            state_d = S_IDLE;
            count_d = 5'd0;
            rep_d   = 8'd0;
         end
         default: begin
            state_d = S_IDLE;
            count_d = 5'd0;
            rep_d   = 8'd0;
         end
      endcase
      ss_d   = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
`ifdef QQ_SEQ_GAP_EN
      busy_d = (state_d == S_RUN) || (state_d == S_GAP);
`else
      busy_d = (state_d == S_RUN);
`endif
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         count_q <= 5'd0;
         rep_q   <= 8'd0;
         tick_q  <= 16'd0;
         len_q   <= 5'd0;
         per_q   <= 16'd1;
         num_q   <= 8'd0;
         ss_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef QQ_SEQ_GAP_EN
         gap_q   <= 16'd0;
         gcnt_q  <= 16'd0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rep_q   <= rep_d;
         tick_q  <= tick_d;
         len_q   <= len_d;
         per_q   <= per_d;
         num_q   <= num_d;
         ss_q    <= ss_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef QQ_SEQ_GAP_EN
         gap_q   <= gap_d;
         gcnt_q  <= gcnt_d;
`endif
      end
   end

   assign count       = count_q;
   assign rep_cnt     = rep_q;
   assign state_start = ss_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_qq_seq_ctrl.sv
// tb/tb_qq_seq_ctrl.sv - self-checking bench for qq_seq_ctrl against a trace-level model.
module tb_qq_seq_ctrl;

   logic        clk_sys = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic [4:0]  seq_len = 5'd0;
   logic [15:0] step_period = 16'd0;
   logic [7:0]  repeat_num = 8'd0;
`ifdef QQ_SEQ_GAP_EN
   logic [15:0] gap_len = 16'd0;
`endif
   logic [4:0]  count;
   logic        state_start;
   logic [7:0]  rep_cnt;
   logic        busy;
   logic        done;

   qq_seq_ctrl dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .stop(stop),
      .seq_len(seq_len), .step_period(step_period), .repeat_num(repeat_num),
`ifdef QQ_SEQ_GAP_EN
      .gap_len(gap_len),
`endif
      .count(count), .state_start(state_start), .rep_cnt(rep_cnt),
      .busy(busy), .done(done)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {
      logic [4:0] count;
      logic [7:0] rep;
      logic       ss;
      logic       busy;
      logic       done;
   } obs_t;

   obs_t exp_q[$];
   obs_t cur = '0;
   int   n_checks = 0;
   int   n_fail = 0;

   function automatic obs_t mk(int c, int r, bit s, bit b, bit d);
      obs_t o;
      o.count = c[4:0];
      o.rep   = r[7:0];
      o.ss    = s;
      o.busy  = b;
      o.done  = d;
      return o;
   endfunction

   // Expected output trace of a whole sequence, cycle by cycle, from the latched inputs.
   function automatic void build_trace();
      int p;
      int n;
      int g;
      p = (step_period == 16'd0) ? 1 : int'(step_period);
      n = int'(repeat_num);
      g = 0;
`ifdef QQ_SEQ_GAP_EN
      g = int'(gap_len);
`endif
      exp_q.delete();
      for (int r = 0; r < n; r++) begin
         for (int c = 0; c <= int'(seq_len); c++)
            for (int k = 0; k < p; k++) exp_q.push_back(mk(c, r, 1'b1, 1'b1, 1'b0));
         if (r < n - 1)
            for (int k = 0; k < g; k++) exp_q.push_back(mk(0, r + 1, 1'b0, 1'b1, 1'b0));
      end
      exp_q.push_back(mk(0, (n == 0) ? 0 : n - 1, 1'b0, 1'b0, 1'b1));
   endfunction

   task automatic check(string name, int act, int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge clk_sys) begin
      if (!rst_n) begin
         exp_q.delete();
         cur = '0;
      end else if (cur.busy || cur.done) begin
         if (stop) begin
            exp_q.delete();
            cur = '0;
         end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
         end else begin
            cur = '0;
         end
      end else if (start && !stop) begin
         build_trace();
         cur = exp_q.pop_front();
      end
      #1;
      n_checks++;
      if ({count, rep_cnt, state_start, busy, done} !== cur) begin
         n_fail++;
         $display("FAIL model_cmp: got count=%0d rep=%0d ss=%0b busy=%0b done=%0b expected count=%0d rep=%0d ss=%0b busy=%0b done=%0b at %0t",
                  count, rep_cnt, state_start, busy, done,
                  cur.count, cur.rep, cur.ss, cur.busy, cur.done, $time);
      end
   end

   task automatic sample_next(output obs_t o);
      @(posedge clk_sys);
      #1;
      o = {count, rep_cnt, state_start, busy, done};
      #1;
   endtask

   task automatic setup(int l, int p, int n, int g);
      seq_len     = l[4:0];
      step_period = p[15:0];
      repeat_num  = n[7:0];
`ifdef QQ_SEQ_GAP_EN
      gap_len     = g[15:0];
`else
      if (g != 0) $display("gap request %0d ignored in this build", g);
`endif
   endtask

   initial begin
      obs_t o;
      int   basic_cnt[8];
      int   deg_cnt[6];
      int   deg_rep[6];
      int   gap_ss[5];
      bit   seen;
      int   dsum;
      basic_cnt = '{0, 0, 1, 1, 2, 2, 3, 3};
      deg_cnt   = '{0, 1, 0, 1, 0, 1};
      deg_rep   = '{0, 0, 1, 1, 2, 2};
      gap_ss    = '{1, 0, 0, 0, 1};

      repeat (3) @(posedge clk_sys);
      #2 rst_n = 1'b1;
      check("reset_outputs", int'({count, rep_cnt, state_start, busy, done}), 0);

      // basic sequence
      setup(3, 2, 1, 0);
      start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sample_next(o);
         start = 1'b0;
         check("basic_count", int'(o.count), basic_cnt[i]);
         check("basic_ss", int'(o.ss), 1);
      end
      sample_next(o);
      check("basic_done", int'(o.done), 1);
      sample_next(o);
      check("basic_done_clear", int'({o.done, o.busy}), 0);

      // degenerate period with repetitions
      setup(1, 0, 3, 0);
      start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         sample_next(o);
         start = 1'b0;
         check("deg_count", int'(o.count), deg_cnt[i]);
         check("deg_rep", int'(o.rep), deg_rep[i]);
      end
      dsum = 0;
      for (int i = 0; i < 4; i++) begin
         sample_next(o);
         dsum += int'(o.done);
      end
      check("deg_done_pulses", dsum, 1);

      // abort at cycle 4, then restart
      setup(3, 2, 1, 0);
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) stop = 1'b1;
         sample_next(o);
         start = 1'b0;
      end
      stop = 1'b0;
      check("abort_idle", int'({o.count, o.rep, o.ss, o.busy, o.done}), 0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         sample_next(o);
         if (o.done) seen = 1'b1;
      end
      check("abort_no_done", int'(seen), 0);
      start = 1'b1;
      sample_next(o);
      start = 1'b0;
      check("restart_run", int'({o.count, o.ss, o.busy}), 3);
      repeat (10) sample_next(o);

      // zero repetitions
      setup(2, 1, 0, 0);
      start = 1'b1;
      sample_next(o);
      start = 1'b0;
      check("zero_rep_done", int'({o.ss, o.busy, o.done}), 1);
      sample_next(o);
      check("zero_rep_idle", int'({o.ss, o.busy, o.done}), 0);

      // start pulsed mid-run is ignored
      setup(3, 2, 1, 0);
      start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         sample_next(o);
         start = (i == 3);
      end
      start = 1'b0;
      check("midrun_start_done", int'(o.done), 1);
      sample_next(o);

      // start and stop together in idle
      start = 1'b1;
      stop  = 1'b1;
      sample_next(o);
      start = 1'b0;
      stop  = 1'b0;
      check("start_stop_idle", int'({o.ss, o.busy, o.done}), 0);
      repeat (3) sample_next(o);

`ifdef QQ_SEQ_GAP_EN
      setup(0, 1, 2, 3);
      start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sample_next(o);
         start = 1'b0;
         check("gap_ss", int'(o.ss), gap_ss[i]);
      end
      sample_next(o);
      check("gap_done", int'(o.done), 1);
      sample_next(o);
`else
      check("gap_table_len", $size(gap_ss), 5);
`endif

      // asynchronous reset mid-run
      setup(3, 2, 3, 0);
      start = 1'b1;
      repeat (3) begin
         sample_next(o);
         start = 1'b0;
      end
      #3 rst_n = 1'b0;
      #1;
      check("async_reset", int'({count, rep_cnt, state_start, busy, done}), 0);
      @(posedge clk_sys);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sample_next(o);
         check("post_reset_idle", int'({o.ss, o.busy, o.done}), 0);
      end

      // randomized traffic; parameter churn during a sequence must not matter
      for (int i = 0; i < 3000; i++) begin
         start       = ($urandom_range(0, 5) == 0);
         stop        = ($urandom_range(0, 49) == 0);
         seq_len     = 5'($urandom_range(0, 4));
         step_period = 16'($urandom_range(0, 3));
         repeat_num  = 8'($urandom_range(0, 3));
`ifdef QQ_SEQ_GAP_EN
         gap_len     = 16'($urandom_range(0, 3));
`endif
         sample_next(o);
      end
      start = 1'b0;
      stop  = 1'b0;
      repeat (200) sample_next(o);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
